// File: rtl/mdio_master.sv
// MDIO (IEEE 802.3 clause 22) management master: serialises one read or write frame per request.
// MDC is derived from HCLK by an internal divider that only runs while a frame is in flight.
module mdio_master #(
  parameter int unsigned MDC_DIV     = 10,
  parameter int unsigned NO_PREAMBLE = 0
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        REQ_VALID,
  output logic        REQ_READY,
  input  logic        REQ_WRITE,
  input  logic [4:0]  PHY_ADDR,
  input  logic [4:0]  REG_ADDR,
  input  logic [15:0] WDATA,
  output logic [15:0] RDATA,
  output logic        RDATA_VALID,
  output logic        BUSY,
  output logic        MDC,
  output logic        MDIO_O,
  output logic        MDIO_OE,
  input  logic        MDIO_I
);

  typedef enum logic [2:0] {
    StIdle, StPreamble, StHeader, StTurnaround, StData, StDone
  } state_e;

  localparam logic [8:0] DivHalf = 9'(MDC_DIV);
  localparam logic [8:0] DivRise = 9'(MDC_DIV - 1);
  localparam logic [8:0] DivLast = 9'(2 * MDC_DIV - 1);

  state_e      state_q, state_d;
  logic [8:0]  div_q, div_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        wr_q, wr_d;
  logic [4:0]  phy_q, phy_d;
  logic [4:0]  reg_q, reg_d;
  logic [15:0] wdata_q, wdata_d;
  logic [15:0] shift_q, shift_d;
  logic [15:0] rdata_q, rdata_d;
  logic        rv_q, rv_d;
  logic        busy_q, busy_d;
  logic        mdc_q, mdc_d;
  logic        mo_q, mo_d;
  logic        oe_q, oe_d;

  logic        accept;
  logic        bit_end;
  logic [4:0]  last_idx;
  logic [13:0] header_d;

  assign REQ_READY = !busy_q && !HRESET;
  assign accept    = REQ_VALID && REQ_READY;

  always_comb begin
    unique case (state_q)
      StPreamble:   last_idx = 5'd31;
      StHeader:     last_idx = 5'd13;
      StTurnaround: last_idx = 5'd1;
      default:      last_idx = 5'd15;
    endcase
  end

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    cnt_d   = cnt_q;
    wr_d    = wr_q;
    phy_d   = phy_q;
    reg_d   = reg_q;
    wdata_d = wdata_q;
    shift_d = shift_q;
    rdata_d = rdata_q;
    rv_d    = 1'b0;
    bit_end = (div_q == DivLast);

    unique case (state_q)
      StIdle, StDone: begin
        state_d = StIdle;
        if (accept) begin
          state_d = (NO_PREAMBLE != 0) ? StHeader : StPreamble;
          div_d   = '0;
          cnt_d   = '0;
          wr_d    = REQ_WRITE;
          phy_d   = PHY_ADDR;
          reg_d   = REG_ADDR;
          wdata_d = WDATA;
          shift_d = '0;
        end
      end
      default: begin
        div_d = bit_end ? 9'd0 : div_q + 9'd1;
        // Read data is captured on the cycle MDC is about to rise.
        if (state_q == StData && !wr_q && div_q == DivRise) begin
          shift_d = {shift_q[14:0], MDIO_I};
        end
        if (bit_end) begin
          if (cnt_q == last_idx) begin
            cnt_d = '0;
            case (state_q)
              StPreamble:   state_d = StHeader;
              StHeader:     state_d = StTurnaround;
              StTurnaround: state_d = StData;
              default: begin
                state_d = StDone;
                if (!wr_q) begin
                  rdata_d = shift_q;
                  rv_d    = 1'b1;
                end
              end
            endcase
          end else begin
            cnt_d = cnt_q + 5'd1;
          end
        end
      end
    endcase

    // Line outputs are a function of the next bit position, so they only move at bit starts.
    header_d = {2'b01, (wr_d ? 2'b01 : 2'b10), phy_d, reg_d};
    busy_d   = (state_d != StIdle) && (state_d != StDone);
    mdc_d    = busy_d && (div_d >= DivHalf);
    mo_d     = 1'b1;
    oe_d     = 1'b0;
    unique case (state_d)
      StPreamble: oe_d = 1'b1;
      StHeader: begin
        oe_d = 1'b1;
        mo_d = header_d[4'd13 - cnt_d[3:0]];
      end
      StTurnaround: begin
        if (wr_d) begin
          oe_d = 1'b1;
          mo_d = (cnt_d == 5'd0);
        end
      end
      StData: begin
        if (wr_d) begin
          oe_d = 1'b1;
          mo_d = wdata_d[4'd15 - cnt_d[3:0]];
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q <= StIdle;
      div_q   <= '0;
      cnt_q   <= '0;
      wr_q    <= 1'b0;
      phy_q   <= '0;
      reg_q   <= '0;
      wdata_q <= '0;
      shift_q <= '0;
      rdata_q <= '0;
      rv_q    <= 1'b0;
      busy_q  <= 1'b0;
      mdc_q   <= 1'b0;
      mo_q    <= 1'b1;
      oe_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      phy_q   <= phy_d;
      reg_q   <= reg_d;
      wdata_q <= wdata_d;
      shift_q <= shift_d;
      rdata_q <= rdata_d;
      rv_q    <= rv_d;
      busy_q  <= busy_d;
      mdc_q   <= mdc_d;
      mo_q    <= mo_d;
      oe_q    <= oe_d;
    end
  end

  assign RDATA       = rdata_q;
  assign RDATA_VALID = rv_q;
  assign BUSY        = busy_q;
  assign MDC         = mdc_q;
  assign MDIO_O      = mo_q;
  assign MDIO_OE     = oe_q;

endmodule

// File: tb/tb_mdio_master.sv
// Directed bench for mdio_master: two instances (with and without preamble), frame capture on
// MDC rising edges and a simple PHY model that drives read data after MDC falling edges.
module tb_mdio_master;

  logic HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  logic        HRESET;
  logic        req_write;
  logic [4:0]  phy_addr, reg_addr;
  logic [15:0] wdata;
  logic        mdio_i;
  logic        valid_a, valid_b;

  logic        ready_a, rv_a, busy_a, mdc_a, mo_a, oe_a;
  logic        ready_b, rv_b, busy_b, mdc_b, mo_b, oe_b;
  logic [15:0] rdata_a, rdata_b;

  mdio_master #(.MDC_DIV(2), .NO_PREAMBLE(0)) dut_a (
    .HCLK(HCLK), .HRESET(HRESET), .REQ_VALID(valid_a), .REQ_READY(ready_a),
    .REQ_WRITE(req_write), .PHY_ADDR(phy_addr), .REG_ADDR(reg_addr), .WDATA(wdata),
    .RDATA(rdata_a), .RDATA_VALID(rv_a), .BUSY(busy_a), .MDC(mdc_a),
    .MDIO_O(mo_a), .MDIO_OE(oe_a), .MDIO_I(mdio_i)
  );

  mdio_master #(.MDC_DIV(1), .NO_PREAMBLE(1)) dut_b (
    .HCLK(HCLK), .HRESET(HRESET), .REQ_VALID(valid_b), .REQ_READY(ready_b),
    .REQ_WRITE(req_write), .PHY_ADDR(phy_addr), .REG_ADDR(reg_addr), .WDATA(wdata),
    .RDATA(rdata_b), .RDATA_VALID(rv_b), .BUSY(busy_b), .MDC(mdc_b),
    .MDIO_O(mo_b), .MDIO_OE(oe_b), .MDIO_I(mdio_i)
  );

  logic        sel;
  logic        ready, rv, busy, mdc, mo, oe;
  logic [15:0] rdata;
  always_comb begin
    ready = sel ? ready_b : ready_a;
    rv    = sel ? rv_b    : rv_a;
    busy  = sel ? busy_b  : busy_a;
    mdc   = sel ? mdc_b   : mdc_a;
    mo    = sel ? mo_b    : mo_a;
    oe    = sel ? oe_b    : oe_a;
    rdata = sel ? rdata_b : rdata_a;
  end

  int tests, fails;

  // Per-frame observations filled in by run_frame.
  int          f_busy, f_rise, f_rv, f_wait;
  logic        f_done, f_aborted, f_rv_done, f_ready, f_mdc, f_oe;
  logic [15:0] f_rd;
  logic [63:0] f_bits, f_oes;

  logic        swap_req, nxt_write;
  logic [4:0]  nxt_phy, nxt_reg;
  logic [15:0] nxt_wdata, phy_data;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge with a request presented; returns at the DONE cycle, or right after
  // asserting HRESET once abort_rise MDC rising edges have been seen.
  task automatic run_frame(input int abort_rise);
    int   pre;
    logic pm;
    pre = sel ? 0 : 32;
    f_busy = 0; f_rise = 0; f_rv = 0; f_wait = 0;
    f_done = 1'b0; f_aborted = 1'b0; f_rv_done = 1'b0; f_ready = 1'b0;
    f_mdc = 1'b1; f_oe = 1'b1; f_rd = 16'hxxxx; f_bits = '0; f_oes = '0;
    pm = mdc;
    for (int c = 0; c < 2000; c++) begin
      @(negedge HCLK);
      if (rv) f_rv++;
      if (busy) begin
        if (f_busy == 0) begin
          f_wait = c + 1;
          if (swap_req) begin
            req_write = nxt_write; phy_addr = nxt_phy; reg_addr = nxt_reg; wdata = nxt_wdata;
          end else begin
            valid_a = 1'b0; valid_b = 1'b0;
          end
        end
        f_busy++;
        if (mdc && !pm) begin
          f_bits = {f_bits[62:0], mo};
          f_oes  = {f_oes[62:0], oe};
          f_rise++;
          if (abort_rise != 0 && f_rise == abort_rise) begin
            HRESET = 1'b1;
            f_aborted = 1'b1;
            break;
          end
        end
        if (!mdc && pm) begin
          if (f_rise >= pre + 16 && f_rise < pre + 32)
            mdio_i = phy_data[4'(15 - (f_rise - pre - 16))];
          else
            mdio_i = 1'b0;
        end
      end else if (f_busy != 0) begin
        f_done = 1'b1; f_rd = rdata; f_rv_done = rv; f_ready = ready; f_mdc = mdc; f_oe = oe;
        break;
      end
      pm = mdc;
    end
  endtask

  initial begin
    tests = 0; fails = 0; sel = 1'b0;
    HRESET = 1'b1; valid_a = 1'b1; valid_b = 1'b1;
    req_write = 1'b1; phy_addr = '0; reg_addr = '0; wdata = '0; mdio_i = 1'b0;
    swap_req = 1'b0; nxt_write = 1'b0; nxt_phy = '0; nxt_reg = '0; nxt_wdata = '0;
    phy_data = '0;

    // Reset state, with REQ_VALID held during reset.
    repeat (3) @(negedge HCLK);
    check("rst_ready", 64'(ready), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_mdc", 64'(mdc), 64'd0);
    check("rst_mdio_o", 64'(mo), 64'd1);
    check("rst_mdio_oe", 64'(oe), 64'd0);
    check("rst_rdata", 64'(rdata), 64'h0);
    check("rst_rv", 64'(rv), 64'd0);
    check("rst_busy_b", 64'(busy_b), 64'd0);
    HRESET = 1'b0; valid_a = 1'b0; valid_b = 1'b0;
    repeat (5) @(negedge HCLK);
    check("idle_busy", 64'(busy), 64'd0);
    check("idle_ready", 64'(ready), 64'd1);
    check("idle_mdc", 64'(mdc), 64'd0);

    // Write PHY 0x01 REG 0x04 data 0xABCD, MDC_DIV=2.
    req_write = 1'b1; phy_addr = 5'h01; reg_addr = 5'h04; wdata = 16'hABCD; valid_a = 1'b1;
    run_frame(0);
    check("wr_done", 64'(f_done), 64'd1);
    check("wr_wait", 64'(f_wait), 64'd1);
    check("wr_busy_cycles", 64'(f_busy), 64'd256);
    check("wr_bits", f_bits, 64'hFFFF_FFFF_5092_ABCD);
    check("wr_oe", f_oes, 64'hFFFF_FFFF_FFFF_FFFF);
    check("wr_rise_count", 64'(f_rise), 64'd64);
    check("wr_no_rv", 64'(f_rv), 64'd0);
    check("wr_rdata_kept", 64'(f_rd), 64'h0);
    check("wr_done_mdc", 64'(f_mdc), 64'd0);
    check("wr_done_oe", 64'(f_oe), 64'd0);
    @(negedge HCLK);

    // Read PHY 0x1F REG 0x02, PHY returns 0x1234.
    req_write = 1'b0; phy_addr = 5'h1F; reg_addr = 5'h02; phy_data = 16'h1234; valid_a = 1'b1;
    run_frame(0);
    check("rd_done", 64'(f_done), 64'd1);
    check("rd_busy_cycles", 64'(f_busy), 64'd256);
    check("rd_bits", f_bits, 64'hFFFF_FFFF_6F8B_FFFF);
    check("rd_oe", f_oes, 64'hFFFF_FFFF_FFFC_0000);
    check("rd_rv_at_done", 64'(f_rv_done), 64'd1);
    check("rd_rv_count", 64'(f_rv), 64'd1);
    check("rd_rdata", 64'(f_rd), 64'h1234);
    @(negedge HCLK);
    check("rd_rv_one_cycle", 64'(rv), 64'd0);
    check("rd_rdata_hold", 64'(rdata), 64'h1234);

    // No preamble, MDC_DIV=1: write PHY 0x05 REG 0x1A data 0x0F0F.
    sel = 1'b1;
    req_write = 1'b1; phy_addr = 5'h05; reg_addr = 5'h1A; wdata = 16'h0F0F; valid_b = 1'b1;
    run_frame(0);
    check("np_done", 64'(f_done), 64'd1);
    check("np_busy_cycles", 64'(f_busy), 64'd64);
    check("np_rise_count", 64'(f_rise), 64'd32);
    check("np_bits", f_bits, 64'h0000_0000_52EA_0F0F);
    check("np_oe", f_oes, 64'h0000_0000_FFFF_FFFF);
    @(negedge HCLK);
    sel = 1'b0;

    // Back-to-back: REQ_VALID held, fields switch to a read while the write is in flight.
    req_write = 1'b1; phy_addr = 5'h0A; reg_addr = 5'h15; wdata = 16'h5A5A; valid_a = 1'b1;
    swap_req = 1'b1; nxt_write = 1'b0; nxt_phy = 5'h03; nxt_reg = 5'h11; nxt_wdata = 16'h0000;
    run_frame(0);
    check("b2b1_done", 64'(f_done), 64'd1);
    check("b2b1_busy_cycles", 64'(f_busy), 64'd256);
    check("b2b1_bits", f_bits, 64'hFFFF_FFFF_5556_5A5A);
    check("b2b1_ready_in_done", 64'(f_ready), 64'd1);
    swap_req = 1'b0; phy_data = 16'hBEEF;
    run_frame(0);
    check("b2b2_wait", 64'(f_wait), 64'd1);
    check("b2b2_done", 64'(f_done), 64'd1);
    check("b2b2_bits", f_bits, 64'hFFFF_FFFF_61C7_FFFF);
    check("b2b2_rdata", 64'(f_rd), 64'hBEEF);
    check("b2b2_rv", 64'(f_rv), 64'd1);
    @(negedge HCLK);
    check("b2b_no_extra_frame", 64'(busy), 64'd0);
    repeat (4) @(negedge HCLK);
    check("b2b_still_idle", 64'(busy), 64'd0);

    // Reset during read DATA bit 5 (frame bit 53), then a clean read.
    req_write = 1'b0; phy_addr = 5'h1F; reg_addr = 5'h02; phy_data = 16'h1234; valid_a = 1'b1;
    run_frame(54);
    check("abort_reached", 64'(f_aborted), 64'd1);
    @(negedge HCLK);
    check("abort_mdc", 64'(mdc), 64'd0);
    check("abort_oe", 64'(oe), 64'd0);
    check("abort_mdio_o", 64'(mo), 64'd1);
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_rdata", 64'(rdata), 64'h0);
    check("abort_rv", 64'(rv), 64'd0);
    check("abort_ready_in_reset", 64'(ready), 64'd0);
    check("abort_no_rv_pulse", 64'(f_rv), 64'd0);
    HRESET = 1'b0;
    @(negedge HCLK);
    check("post_abort_idle", 64'(busy), 64'd0);
    req_write = 1'b0; phy_addr = 5'h00; reg_addr = 5'h1F; phy_data = 16'h8001; valid_a = 1'b1;
    run_frame(0);
    check("post_done", 64'(f_done), 64'd1);
    check("post_busy_cycles", 64'(f_busy), 64'd256);
    check("post_bits", f_bits, 64'hFFFF_FFFF_607F_FFFF);
    check("post_oe", f_oes, 64'hFFFF_FFFF_FFFC_0000);
    check("post_rdata", 64'(f_rd), 64'h8001);
    check("post_rv", 64'(f_rv), 64'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mdio_master.md
MDIO_MASTER -- requirements
Module: mdio_master

Interface
REQ-001 SHALL have parameter MDC_DIV, default 10, giving HCLK cycles per MDC half-period; legal range 1..255.
REQ-002 SHALL have parameter NO_PREAMBLE, default 0; when 1, the 32-bit preamble is omitted.
REQ-003 SHALL have these ports:
- HCLK  in  1  single clock.
- HRESET  in  1  synchronous, active-high reset.
- REQ_VALID  in  1  management request present.
- REQ_READY  out  1  request accepted when high together with REQ_VALID.
- REQ_WRITE  in  1  1 = write frame, 0 = read frame.
- PHY_ADDR  in  5  PHY address.
- REG_ADDR  in  5  register address.
- WDATA  in  16  write data.
- RDATA  out  16  last read data.
- RDATA_VALID  out  1  one-cycle pulse when RDATA is updated.
- BUSY  out  1  frame in progress.
- MDC  out  1  management clock.
- MDIO_O  out  1  serial data out.
- MDIO_OE  out  1  MDIO drive enable.
- MDIO_I  in  1  serial data in.

Function
REQ-004 SHALL run entirely on HCLK; all outputs SHALL be registered except REQ_READY.
REQ-005 SHALL drive REQ_READY = !BUSY && !HRESET.
REQ-006 On accept (REQ_VALID && REQ_READY), SHALL capture REQ_WRITE, PHY_ADDR, REG_ADDR and WDATA, and assert BUSY from the next cycle.
REQ-007 SHALL use the FSM states IDLE, PREAMBLE, HEADER, TURNAROUND, DATA and DONE.
REQ-008 SHALL sequence IDLE -> PREAMBLE (32 bits, or skipped when NO_PREAMBLE=1) -> HEADER (14 bits) -> TURNAROUND (2) -> DATA (16) -> DONE (1 HCLK) -> IDLE.
REQ-009 HEADER bits SHALL be sent MSB first: ST=01, OP=01 (write) or 10 (read), PHY_ADDR[4:0], REG_ADDR[4:0].
REQ-010 Each bit period SHALL be 2*MDC_DIV HCLK cycles: MDC low for the first MDC_DIV cycles, high for the next MDC_DIV.
REQ-011 MDIO_O/MDIO_OE SHALL change only at the start of a bit period (MDC low); MDC SHALL be 0 in IDLE and DONE.
REQ-012 Preamble bits SHALL be 1.
REQ-013 Write TURNAROUND SHALL drive 1 then 0; write DATA SHALL drive WDATA[15:0] MSB first, with MDIO_OE=1 through the last data bit.
REQ-014 Read frames SHALL drive MDIO_OE=0 for TURNAROUND and DATA, and MDIO_O=1 whenever MDIO_OE=0.
REQ-015 For reads, MDIO_I SHALL be sampled on the HCLK edge where MDC rises in each DATA bit and shifted in MSB first; TURNAROUND input SHALL be ignored.
REQ-016 DONE SHALL:
- drive BUSY=0 and MDIO_OE=0;
- for reads, load RDATA and pulse RDATA_VALID for exactly 1 cycle;
- for writes, leave RDATA_VALID=0 and RDATA unchanged.
REQ-017 A new request SHALL be acceptable in the DONE cycle (back-to-back); REQ_VALID while BUSY=1 SHALL be ignored.
REQ-018 Total BUSY duration SHALL be 64*2*MDC_DIV HCLK cycles (32*2*MDC_DIV with NO_PREAMBLE=1).
REQ-019 The bit counter and MDC divider SHALL restart at 0 on every accept; the divider SHALL not free-run in IDLE.

Reset
REQ-020 While HRESET=1 at a clock edge, next state SHALL be:
- IDLE;
- MDC=0, MDIO_O=1, MDIO_OE=0;
- BUSY=0, RDATA=16'h0000, RDATA_VALID=0;
- divider and bit counter = 0.
REQ-021 Reset mid-frame SHALL abort the frame without an RDATA_VALID pulse; REQ_VALID during HRESET SHALL NOT be accepted.

Verification
REQ-022 MDC_DIV=2, write PHY=0x01 REG=0x04 WDATA=0xABCD -> MDIO_O bits = 32x1, 01 01 00001 00100 10 1010101111001101; MDIO_OE=1 all 64 bits; BUSY high 256 cycles; no RDATA_VALID.
REQ-023 MDC_DIV=2, read PHY=0x1F REG=0x02, PHY model drives 0x1234 after MDC falling edges -> MDIO_OE low for the final 18 bits; RDATA=0x1234 with a 1-cycle RDATA_VALID at DONE.
REQ-024 NO_PREAMBLE=1, MDC_DIV=1, write -> frame starts with 01, BUSY high 64 cycles, MDC period 2 HCLK.
REQ-025 REQ_VALID held high with alternating requests -> second request accepted exactly in the DONE cycle of the first; requests during BUSY produce no extra frame.
REQ-026 HRESET pulsed during read DATA bit 5 -> next cycle MDC=0, MDIO_OE=0, BUSY=0, RDATA=0x0000, no RDATA_VALID; a following request runs a full, correct frame.
